// File: rtl/uart_cfg_responder.sv
// uart_cfg_responder
//
// Slave side of the UART link-configuration handshake. When the receiver
// reports a configuration request, this block acknowledges it with 0xFF. It
// then collects configuration packets into a shadow copy of the frame format
// and acknowledges each packet. After the END packet has been acknowledged,
// it commits the shadow copy to the active settings. The final ack is sent
// before the commit, so that ack still goes out in the old format.
//
// Ports:
//   clk_i            system clock
//   rst_n_i          asynchronous active-low reset (loads the standard config)
//   enable_i         configuration requests are accepted only while high
//   std_config_i     pulse: load standard config (8 bit / even / 1 stop), IDLE only
//   rx_cfg_req_i     pulse from receiver: configuration request detected
//   rx_data_i        received byte
//   rx_data_valid_i  pulse: rx_data_i valid
//   tx_data_o        byte to transmit (always the 0xFF ack)
//   tx_req_o         one-cycle transmit request
//   tx_done_i        pulse: transmitter finished the requested byte
//   data_width_o     active data-width code
//   parity_mode_o    active parity code
//   stop_bits_o      active stop-bits code
//   busy_o           high while a handshake is in progress
//   cfg_done_o       pulse: new configuration committed
//   cfg_fail_o       pulse: handshake aborted (reserved option or timeout)

module uart_cfg_responder #(
   parameter int TIMEOUT_CYCLES = 10000
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       enable_i,
   input  logic       std_config_i,
   input  logic       rx_cfg_req_i,
   input  logic [7:0] rx_data_i,
   input  logic       rx_data_valid_i,
   output logic [7:0] tx_data_o,
   output logic       tx_req_o,
   input  logic       tx_done_i,
   output logic [1:0] data_width_o,
   output logic [1:0] parity_mode_o,
   output logic [1:0] stop_bits_o,
   output logic       busy_o,
   output logic       cfg_done_o,
   output logic       cfg_fail_o
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   // Count value seen in the last allowed idle cycle of WAIT_PKT.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

   localparam logic [1:0] STD_DATA_WIDTH = 2'b11;
   localparam logic [1:0] STD_PARITY     = 2'b00;
   localparam logic [1:0] STD_STOP_BITS  = 2'b00;
   localparam logic [7:0] ACK_BYTE       = 8'hFF;

   localparam logic [1:0] ID_END    = 2'b00;
   localparam logic [1:0] ID_WIDTH  = 2'b01;
   localparam logic [1:0] ID_PARITY = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      SEND_ACKN,
      WAIT_TX,
      WAIT_PKT
   } state_t;

   state_t           state_reg, state_next;
   logic [1:0]       data_width_reg, data_width_next;
   logic [1:0]       parity_reg, parity_next;
   logic [1:0]       stop_bits_reg, stop_bits_next;
   logic [1:0]       sh_data_width_reg, sh_data_width_next;
   logic [1:0]       sh_parity_reg, sh_parity_next;
   logic [1:0]       sh_stop_bits_reg, sh_stop_bits_next;
   logic             end_flag_reg, end_flag_next;
   logic [CNT_W-1:0] timeout_cnt_reg, timeout_cnt_next;
   logic [7:0]       tx_data_reg, tx_data_next;
   logic             cfg_done_reg, cfg_done_next;
   logic             cfg_fail_reg, cfg_fail_next;

   logic [1:0]       pkt_id;
   logic [1:0]       pkt_option;
   logic             unused_rx_hi_bits;

   assign pkt_id     = rx_data_i[1:0];
   assign pkt_option = rx_data_i[3:2];
   // The upper nibble of a packet carries no meaning.
   assign unused_rx_hi_bits = ^rx_data_i[7:4];

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_reg         <= IDLE;
         data_width_reg    <= STD_DATA_WIDTH;
         parity_reg        <= STD_PARITY;
         stop_bits_reg     <= STD_STOP_BITS;
         sh_data_width_reg <= STD_DATA_WIDTH;
         sh_parity_reg     <= STD_PARITY;
         sh_stop_bits_reg  <= STD_STOP_BITS;
         end_flag_reg      <= 1'b0;
         timeout_cnt_reg   <= '0;
         tx_data_reg       <= 8'h00;
         cfg_done_reg      <= 1'b0;
         cfg_fail_reg      <= 1'b0;
      end else begin
         state_reg         <= state_next;
         data_width_reg    <= data_width_next;
         parity_reg        <= parity_next;
         stop_bits_reg     <= stop_bits_next;
         sh_data_width_reg <= sh_data_width_next;
         sh_parity_reg     <= sh_parity_next;
         sh_stop_bits_reg  <= sh_stop_bits_next;
         end_flag_reg      <= end_flag_next;
         timeout_cnt_reg   <= timeout_cnt_next;
         tx_data_reg       <= tx_data_next;
         cfg_done_reg      <= cfg_done_next;
         cfg_fail_reg      <= cfg_fail_next;
      end
   end

   always_comb begin
      state_next         = state_reg;
      data_width_next    = data_width_reg;
      parity_next        = parity_reg;
      stop_bits_next     = stop_bits_reg;
      sh_data_width_next = sh_data_width_reg;
      sh_parity_next     = sh_parity_reg;
      sh_stop_bits_next  = sh_stop_bits_reg;
      end_flag_next      = end_flag_reg;
      timeout_cnt_next   = timeout_cnt_reg;
      tx_data_next       = tx_data_reg;
      cfg_done_next      = 1'b0;
      cfg_fail_next      = 1'b0;

      unique case (state_reg)
         IDLE: begin
            if (std_config_i) begin
               data_width_next    = STD_DATA_WIDTH;
               parity_next        = STD_PARITY;
               stop_bits_next     = STD_STOP_BITS;
               sh_data_width_next = STD_DATA_WIDTH;
               sh_parity_next     = STD_PARITY;
               sh_stop_bits_next  = STD_STOP_BITS;
            end
            if (rx_cfg_req_i && enable_i) begin
               // A simultaneous standard-config load is already in the
               // shadow values above; otherwise start from the active set.
               if (!std_config_i) begin
                  sh_data_width_next = data_width_reg;
                  sh_parity_next     = parity_reg;
                  sh_stop_bits_next  = stop_bits_reg;
               end
               end_flag_next = 1'b0;
               tx_data_next  = ACK_BYTE;
               state_next    = SEND_ACKN;
            end
         end

         SEND_ACKN: begin
            state_next = WAIT_TX;
         end

         WAIT_TX: begin
            if (tx_done_i) begin
               if (end_flag_reg) begin
                  data_width_next = sh_data_width_reg;
                  parity_next     = sh_parity_reg;
                  stop_bits_next  = sh_stop_bits_reg;
                  cfg_done_next   = 1'b1;
                  state_next      = IDLE;
               end else begin
                  timeout_cnt_next = '0;
                  state_next       = WAIT_PKT;
               end
            end
         end

         WAIT_PKT: begin
            // A packet arriving in the expiry cycle takes priority.
            if (rx_data_valid_i) begin
               tx_data_next = ACK_BYTE;
               state_next   = SEND_ACKN;
               unique case (pkt_id)
                  ID_END:    end_flag_next      = 1'b1;
                  ID_WIDTH:  sh_data_width_next = pkt_option;
                  ID_PARITY: sh_parity_next     = pkt_option;
                  default: begin
                     if (pkt_option[1]) begin
                        // Reserved stop-bit code: abort without an ack and
                        // drop the pending shadow values.
                        sh_data_width_next = data_width_reg;
                        sh_parity_next     = parity_reg;
                        sh_stop_bits_next  = stop_bits_reg;
                        cfg_fail_next      = 1'b1;
                        state_next         = IDLE;
                     end else begin
                        sh_stop_bits_next = pkt_option;
                     end
                  end
               endcase
            end else if (timeout_cnt_reg == CNT_LAST) begin
               sh_data_width_next = data_width_reg;
               sh_parity_next     = parity_reg;
               sh_stop_bits_next  = stop_bits_reg;
               cfg_fail_next      = 1'b1;
               state_next         = IDLE;
            end else if (timeout_cnt_reg != CNT_MAX) begin
               timeout_cnt_next = timeout_cnt_reg + 1'b1;
            end
         end

         default: state_next = IDLE;
      endcase
   end

   assign tx_data_o     = tx_data_reg;
   assign tx_req_o      = (state_reg == SEND_ACKN);
   assign busy_o        = (state_reg != IDLE);
   assign data_width_o  = data_width_reg;
   assign parity_mode_o = parity_reg;
   assign stop_bits_o   = stop_bits_reg;
   assign cfg_done_o    = cfg_done_reg;
   assign cfg_fail_o    = cfg_fail_reg;

endmodule

// File: doc/uart_cfg_responder.md
Name: uart_cfg_responder

Overview:
Slave-side end of the UART link-configuration handshake. It answers a master's configuration request, acknowledges each configuration packet, and applies the new frame format.
- Sits in the control unit between the receiver (config-request detect, received bytes) and the transmitter (acknowledgment bytes).
- Drives the active data-width / parity / stop-bits settings consumed by both.

Parameters:
TIMEOUT_CYCLES, 10000, clock cycles allowed between packets while waiting for a configuration packet (10 ms at 1 MHz).

Ports:
clk_i  input  1  system clock
rst_n_i  input  1  asynchronous active-low reset
enable_i  input  1  configuration requests accepted when high (CTR.ENREQ)
std_config_i  input  1  one-cycle pulse: load standard configuration
rx_cfg_req_i  input  1  one-cycle pulse from receiver: 10 ms RX-low request detected
rx_data_i  input  8  received byte
rx_data_valid_i  input  1  one-cycle pulse, rx_data_i valid
tx_data_o  output  8  byte to transmit
tx_req_o  output  1  one-cycle transmit request
tx_done_i  input  1  one-cycle pulse, transmitter finished the requested byte
data_width_o  output  2  active data width code
parity_mode_o  output  2  active parity code
stop_bits_o  output  2  active stop-bits code
busy_o  output  1  high whenever state != IDLE
cfg_done_o  output  1  one-cycle pulse, new configuration committed
cfg_fail_o  output  1  one-cycle pulse, configuration aborted

Behaviour:
Interface:
- One clock, clk_i.
- Reset rst_n_i is asynchronous, active-low.

Reset:
- state = IDLE.
- data_width_o = 2'b11, parity_mode_o = 2'b00, stop_bits_o = 2'b00 (8 bit, even, 1 stop).
- Shadow registers equal to active values.
- tx_data_o = 0; tx_req_o, busy_o, cfg_done_o, cfg_fail_o = 0.
- Timeout counter = 0; end flag = 0.

States: IDLE, SEND_ACKN, WAIT_TX, WAIT_PKT.

IDLE:
- rx_cfg_req_i && enable_i: copy active config into shadow, clear end flag, go to SEND_ACKN.
- std_config_i: load the standard config into active and shadow next cycle. Ignored outside IDLE.
- If std_config_i and rx_cfg_req_i arrive in the same cycle, both take effect: standard config is loaded, then the request is processed.

SEND_ACKN:
- tx_req_o = 1 for exactly one cycle, tx_data_o = 8'hFF; go to WAIT_TX.
- tx_data_o is held stable until tx_done_i.

WAIT_TX:
- On tx_done_i with end flag = 1: copy shadow into active outputs, pulse cfg_done_o, go to IDLE. The new values and cfg_done_o are visible together in the next cycle.
- The commit happens only after the final ack is sent, so the ack always uses the old format.
- On tx_done_i with end flag = 0: clear timeout counter, go to WAIT_PKT.

WAIT_PKT: on rx_data_valid_i, decode rx_data_i as id = [1:0], option = [3:2]; bits [7:4] are ignored.
- id 01: shadow data width = option, go to SEND_ACKN.
- id 10: shadow parity = option (all four codes are legal), go to SEND_ACKN.
- id 11 with option 00 or 01: shadow stop bits = option, go to SEND_ACKN.
- id 11 with option 10 or 11 (reserved): pulse cfg_fail_o, discard shadow, go to IDLE, no ack.
- id 00 (END): set end flag, go to SEND_ACKN.
- No rx_data_valid_i for TIMEOUT_CYCLES consecutive cycles: pulse cfg_fail_o, go to IDLE, active config unchanged.
- Data valid in the same cycle as timeout expiry: the data wins.

General rules:
- rx_data_valid_i outside WAIT_PKT is dropped.
- rx_cfg_req_i outside IDLE is ignored.
- Active outputs change only at a commit or at a std_config_i load.
- Timeout counter width is $clog2(TIMEOUT_CYCLES+1). It saturates and does not wrap.
- Reset mid-operation: immediate return to IDLE with the standard config; nothing from the shadow is committed.

Test Plan:
- Full sequence (TIMEOUT_CYCLES = 100): rx_cfg_req_i, then 0x01, 0x06, 0x07, 0x00, with tx_done_i 5 cycles after each tx_req_o.
  - Response: 5 acks of 0xFF.
  - After the last tx_done_i: data_width_o = 00, parity_mode_o = 01, stop_bits_o = 01, one cfg_done_o pulse, busy_o = 0.
- Reserved stop bits: request, ack, then byte 0x0B.
  - Response: cfg_fail_o pulse, no further tx_req_o.
  - Outputs remain 11/00/00 and state returns to IDLE.
- Timeout: request, ack done, then no byte for 100 cycles.
  - Response: cfg_fail_o pulse exactly 100 cycles after entering WAIT_PKT; config unchanged.
  - A byte arriving in the expiry cycle is accepted instead.
- Disabled / ignored inputs:
  - enable_i = 0 with rx_cfg_req_i: no tx_req_o, busy_o stays 0.
  - rx_data_valid_i while in IDLE: no effect.
- Reset mid-sequence: after 0x05 is accepted, assert rst_n_i low asynchronously (between clock edges).
  - Outputs return immediately to 11/00/00, busy_o = 0.
  - A subsequent std_config_i pulse keeps 11/00/00.
- Data bits ignored: byte 0xF2 in WAIT_PKT is treated as a parity = 00 packet.
